cordic_engine: RTL

CORDIC_ENGINE -- requirements
Module: cordic_engine

---
 rtl/cordic_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cordic_engine.sv
// CORDIC engine: iterative rotation/vectoring, UNROLL micro-iterations per clock,
// no gain compensation, saturated registered results.
module cordic_engine #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned ITERS  = 16,
  parameter int unsigned UNROLL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int unsigned WW = WIDTH + 2;  // two guard bits for CORDIC growth
  localparam int unsigned CW = 5;
  localparam int unsigned SH = 32 - WIDTH;  // Q2.30 master -> Q2.(WIDTH-2)

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic signed [WW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic signed [WW-1:0]    xc, yc, zc, xsh, ysh, at;
  logic [CW-1:0]           idx;
  logic                    neg;

  // atan(2^-i) rounded from a fixed Q2.30 master table
  function automatic logic signed [WW-1:0] atan_lut(input logic [CW-1:0] i);
    logic [31:0] m;
    logic [31:0] r;
    case (i)
      5'd0:    m = 32'h3243F6A9;
      5'd1:    m = 32'h1DAC6705;
      5'd2:    m = 32'h0FADBAFD;
      5'd3:    m = 32'h07F56EA7;
      5'd4:    m = 32'h03FEAB77;
      5'd5:    m = 32'h01FFD55C;
      5'd6:    m = 32'h00FFFAAB;
      5'd7:    m = 32'h007FFF55;
      5'd8:    m = 32'h003FFFEB;
      5'd9:    m = 32'h001FFFFD;
      5'd10:   m = 32'h00100000;
      5'd11:   m = 32'h00080000;
      5'd12:   m = 32'h00040000;
      5'd13:   m = 32'h00020000;
      5'd14:   m = 32'h00010000;
      5'd15:   m = 32'h00008000;
      default: m = 32'h00000000;
    endcase
    r = (m + (32'd1 << (SH - 1))) >> SH;
    return $signed(WW'(r));
  endfunction

  // clamp a working value into the signed WIDTH range
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WW-1:0] v);
    logic [2:0]              top;
    logic signed [WIDTH-1:0] res;
    top = v[WW-1:WIDTH-1];
    if (top == 3'b000 || top == 3'b111) begin
      res = v[WIDTH-1:0];
    end else if (v[WW-1]) begin
      res = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

  // chain UNROLL micro-rotations starting at iteration cnt_q
  always_comb begin
    xc  = x_q;
    yc  = y_q;
    zc  = z_q;
    idx = '0;
    neg = 1'b0;
    xsh = '0;
    ysh = '0;
    at  = '0;
    for (int k = 0; k < UNROLL; k++) begin
      idx = cnt_q + CW'(k);
      // neg means d = -1
      neg = mode_q ? ~yc[WW-1] : zc[WW-1];
      xsh = xc >>> idx;
      ysh = yc >>> idx;
      at  = atan_lut(idx);
      if (neg) begin
        xc = xc + ysh;
        yc = yc - xsh;
        zc = zc + at;
      end else begin
        xc = xc - ysh;
        yc = yc + xsh;
        zc = zc - at;
      end
    end
  end

  // FSM next state, operand capture and result load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          mode_d  = mode;
          x_d     = {{2{x_in[WIDTH-1]}}, x_in};
          y_d     = {{2{y_in[WIDTH-1]}}, y_in};
          z_d     = {{2{z_in[WIDTH-1]}}, z_in};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        x_d   = xc;
        y_d   = yc;
        z_d   = zc;
        cnt_d = cnt_q + CW'(UNROLL);
        if (cnt_q == CW'(ITERS - UNROLL)) begin
          state_d = DONE;
          xo_d    = sat(xc);
          yo_d    = sat(yc);
          zo_d    = sat(zc);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign x_out = xo_q;
  assign y_out = yo_q;
  assign z_out = zo_q;

endmodule
